// File: rtl/meas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | meas_pkg : shared FSM state type and defaults for meas_frame_tx      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] DEF_HEADER = 8'hA5;
  localparam int         DEF_ACK_TO = 4;

endpackage
`default_nettype wire

// File: rtl/frame_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_chk : running XOR of the frame bytes fed to it                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module frame_chk (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       clear,
  input  logic       accumulate,
  output logic [7:0] chk
);

  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clear)
      chk_d = 8'h00;
    else if (accumulate)
      chk_d = chk_q ^ byte_in;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n)
      chk_q <= 8'h00;
    else
      chk_q <= chk_d;
  end

  assign chk = chk_q;

endmodule
`default_nettype wire

// File: rtl/meas_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | meas_frame_tx : frames a measurement word (HEADER, payload, CHK) and |
// | hands it byte by byte to a UART. FRAME_SEQ_EN adds a sequence byte.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module meas_frame_tx
  import meas_pkg::*;
#(
  parameter int         NBYTES = 3,
  parameter logic [7:0] HEADER = DEF_HEADER,
  parameter int         ACK_TO = DEF_ACK_TO
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic [8*NBYTES-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  output logic                frame_done,
  output logic                overrun
);

`ifdef FRAME_SEQ_EN
  localparam int SEQ_N = 1;
`else
  localparam int SEQ_N = 0;
`endif
  localparam int               IDX_W    = $clog2(NBYTES + 4);
  localparam int               TO_W     = $clog2(ACK_TO + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES + 1 + SEQ_N);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx, pay_idx;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [8*NBYTES-1:0] data_q, data_d;
  logic [7:0]          tx_data_q, tx_data_d, sel_byte, chk;
  logic                load, chk_clear, chk_acc;
`ifdef FRAME_SEQ_EN
  logic [7:0]          seq_q, seq_d;
`endif

  // Index of the byte presented on the next entry into START.
  assign nxt_idx = (state_q == ST_IDLE) ? '0 : idx_q + IDX_W'(1);
  assign pay_idx = nxt_idx - IDX_W'(1 + SEQ_N);

  always_comb begin
    sel_byte = chk;
    if (nxt_idx == '0)
      sel_byte = HEADER;
`ifdef FRAME_SEQ_EN
    else if (nxt_idx == IDX_W'(1))
      sel_byte = seq_q;
`endif
    else if (nxt_idx != LAST_IDX) begin
      for (int k = 0; k < NBYTES; k++)
        if (pay_idx == IDX_W'(k))
          sel_byte = data_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    data_d     = data_q;
    load       = 1'b0;
    chk_clear  = 1'b0;
    chk_acc    = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
`ifdef FRAME_SEQ_EN
    seq_d      = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          data_d    = data_in;
          idx_d     = '0;
          chk_clear = 1'b1;
          load      = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          to_cnt_d = '0;
          // HEADER and CHK itself stay out of the checksum.
          chk_acc  = (idx_q != '0) && (idx_q != LAST_IDX);
          state_d  = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy || to_cnt_q == TO_W'(ACK_TO - 1))
          state_d = ST_WAIT_LO;
        else
          to_cnt_d = to_cnt_q + TO_W'(1);
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            load    = 1'b1;
            state_d = ST_START;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
`ifdef FRAME_SEQ_EN
        seq_d      = seq_q + 8'd1;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_data_d = load ? sel_byte : tx_data_q;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      tx_data_q <= 8'h00;
`ifdef FRAME_SEQ_EN
      seq_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
`ifdef FRAME_SEQ_EN
      seq_q     <= seq_d;
`endif
    end
  end

  frame_chk u_chk (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .byte_in    (tx_data_q),
    .clear      (chk_clear),
    .accumulate (chk_acc),
    .chk        (chk)
  );

  assign data_ready = (state_q == ST_IDLE);
  assign overrun    = data_valid && (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;

endmodule
`default_nettype wire
